shift_xcvr: RTL and testbench

//  Parametrised serial transceiver built around a WIDTH-bit shift register.

---
 rtl/shift_xcvr.sv | 159 +++++++++++++++
 tb/tb_shift_xcvr.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/shift_xcvr.sv
`default_nettype none
// ============================================================================
//  Module      : shift_xcvr
//  Description : Parametrised serial transceiver around a WIDTH-bit shift
//                register. A parallel word accepted via load_valid/load_ready
//                is shifted out on sout one bit per clock while sin is shifted
//                in. The received word is presented on dout together with a
//                one-cycle done pulse. A transfer in progress can be aborted.
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous reset, active-low
//                din        - parallel word to transmit
//                load_valid - din valid
//                load_ready - block can accept a word (IDLE)
//                abort      - cancel the transfer in progress
//                sin        - serial input, sampled every edge in SHIFT
//                sout       - serial output (0 outside SHIFT)
//                busy       - high in SHIFT and DONE
//                dout       - last complete received word (registered)
//                done       - one-cycle pulse, dout was just updated
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_xcvr #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             abort,
    input  logic             sin,
    output logic             sout,
    output logic             busy,
    output logic [WIDTH-1:0] dout,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] w_shifted;
    logic             w_out_bit;
    logic             w_last;

    // Bit order only decides which end of the register is the output end and
    // which end receives sin.
    if (LSB_FIRST != 0) begin : g_lsb_first
        assign w_shifted = {sin, r_sreg[WIDTH-1:1]};
        assign w_out_bit = r_sreg[0];
    end else begin : g_msb_first
        assign w_shifted = {r_sreg[WIDTH-2:0], sin};
        assign w_out_bit = r_sreg[WIDTH-1];
    end

    assign w_last = (r_cnt == c_LAST_CNT);
    assign dout   = r_dout;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort beats the final shift edge.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (load_valid) begin
                    w_next_state = c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                if (abort) begin
                    w_next_state = c_ST_IDLE;
                end else if (w_last) begin
                    w_next_state = c_ST_DONE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the registered state only.
    always_comb begin
        load_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        sout       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                load_ready = 1'b1;
            end
            c_ST_SHIFT: begin
                busy = 1'b1;
                sout = w_out_bit;
            end
            c_ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                load_ready = 1'b0;
            end
        endcase
    end

    // Datapath: shift register, bit counter and received-word register.
    // On abort the shift register and counter simply hold; their contents are
    // irrelevant because the next load overwrites both.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_dout <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (load_valid) begin
                        r_sreg <= din;
                        r_cnt  <= '0;
                    end
                end
                c_ST_SHIFT: begin
                    if (!abort) begin
                        r_sreg <= w_shifted;
                        if (w_last) begin
                            r_cnt  <= '0;
                            r_dout <= w_shifted;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_xcvr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_xcvr
//  Description : Self-checking bench for shift_xcvr. Two configurations run in
//                parallel (WIDTH=8 MSB-first, WIDTH=16 LSB-first). A driver
//                issues directed and random transfers and pushes the expected
//                received word into a queue; a monitor pops and compares it
//                whenever done is seen, and tracks the value dout must hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_xcvr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int W  = (g == 0) ? 8 : 16;
        localparam int LF = (g == 0) ? 0 : 1;
        localparam logic [W-1:0] c_D1 = (W == 8) ? W'(8'hA5) : W'(16'h8001);

        logic         rst = 1'b0;
        logic         rst_q = 1'b0;
        logic [W-1:0] din = '0;
        logic         load_valid = 1'b0;
        logic         load_ready;
        logic         abort = 1'b0;
        logic         sin;
        logic         sout;
        logic         busy;
        logic [W-1:0] dout;
        logic         done;
        int           sin_mode = 0;    // 0 loopback, 1 random, 2 held high
        logic         sin_ext = 1'b0;
        logic [W-1:0] exp_q[$];
        logic [W-1:0] model_dout = '0;
        bit           fin = 1'b0;

        assign sin = (sin_mode == 0) ? sout : sin_ext;

        shift_xcvr #(.WIDTH(W), .LSB_FIRST(LF)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .din        (din),
            .load_valid (load_valid),
            .load_ready (load_ready),
            .abort      (abort),
            .sin        (sin),
            .sout       (sout),
            .busy       (busy),
            .dout       (dout),
            .done       (done)
        );

        always @(posedge clk) rst_q <= rst;

        // Monitor: dout must always equal the last word the model says arrived.
        always @(negedge clk) begin
            if (!rst_q) begin
                model_dout = '0;
                exp_q.delete();
            end else if (done) begin
                if (exp_q.size() == 0) check("unexpected_done", done, 1'b0);
                else model_dout = exp_q.pop_front();
            end
            check("dout", dout, model_dout);
        end

        // One transfer, entered and left at a negedge with the DUT in IDLE.
        task automatic xfer(input logic [W-1:0] d, input int mode, input int abort_at,
                            input bit keep, input bit abort_idle);
            logic [W-1:0] rx;
            logic         b;
            logic         r;
            rx = '0;
            check("idle_ready", load_ready, 1'b1);
            check("idle_busy", busy, 1'b0);
            check("idle_sout", sout, 1'b0);
            sin_mode   = mode;
            din        = d;
            load_valid = 1'b1;
            abort      = abort_idle;
            @(posedge clk);
            for (int k = 0; k < W; k++) begin
                @(negedge clk);
                if (k == 0) begin
                    abort = 1'b0;
                    din   = W'($urandom);
                    if (!keep) load_valid = 1'b0;
                end
                check("shift_busy", busy, 1'b1);
                check("shift_ready", load_ready, 1'b0);
                check("shift_done", done, 1'b0);
                b = (LF != 0) ? d[k] : d[W-1-k];
                check("sout_bit", sout, b);
                sin_ext = (mode == 1) ? 1'($urandom) : 1'b1;
                r = (mode == 0) ? b : sin_ext;
                if (LF != 0) rx[k] = r;
                else rx[W-1-k] = r;
                if (k == abort_at) abort = 1'b1;
                if (k == W - 1 && abort_at >= W) exp_q.push_back(rx);
                @(posedge clk);
                if (k == abort_at) begin
                    @(negedge clk);
                    abort = 1'b0;
                    check("abort_ready", load_ready, 1'b1);
                    check("abort_busy", busy, 1'b0);
                    check("abort_done", done, 1'b0);
                    check("abort_sout", sout, 1'b0);
                    return;
                end
            end
            @(negedge clk);
            check("done_pulse", done, 1'b1);
            check("done_busy", busy, 1'b1);
            check("done_ready", load_ready, 1'b0);
            check("done_sout", sout, 1'b0);
            @(negedge clk);
            check("post_done", done, 1'b0);
            check("post_busy", busy, 1'b0);
        endtask

        task automatic reset_mid(input logic [W-1:0] d);
            sin_mode   = 0;
            din        = d;
            load_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            load_valid = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("rst_busy", busy, 1'b0);
            check("rst_ready", load_ready, 1'b1);
            check("rst_sout", sout, 1'b0);
            check("rst_done", done, 1'b0);
            rst = 1'b1;
            @(negedge clk);
        endtask

        initial begin
            logic [W-1:0] d;
            int           mode, ab;
            bit           keep;
            repeat (3) @(negedge clk);
            check("reset_ready", load_ready, 1'b1);
            check("reset_busy", busy, 1'b0);
            check("reset_done", done, 1'b0);
            check("reset_sout", sout, 1'b0);
            rst = 1'b1;
            @(negedge clk);
            xfer(c_D1, 0, W, 1'b0, 1'b0);
            xfer(W'(1), 2, W, 1'b0, 1'b0);
            xfer('1, 1, 3, 1'b0, 1'b0);
            xfer(W'($urandom), 0, W - 1, 1'b0, 1'b0);
            xfer(c_D1, 0, W, 1'b0, 1'b1);
            reset_mid('1);
            for (int i = 0; i < 4; i++) xfer((i % 2) ? '1 : '0, 0, W, 1'b1, 1'b0);
            load_valid = 1'b0;
            for (int i = 0; i < 30; i++) begin
                d    = W'($urandom);
                mode = $urandom_range(0, 2);
                ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, W - 1) : W;
                keep = 1'($urandom_range(0, 1));
                xfer(d, mode, ab, keep, ($urandom_range(0, 3) == 0));
                load_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            repeat (2) @(negedge clk);
            check("queue_empty", exp_q.size(), 0);
            fin = 1'b1;
        end
    end

    initial begin
        wait (g_cfg[0].fin && g_cfg[1].fin);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
